// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and data access (D). Data wins conflicts except when IF has lost
// MAX_IF_WAIT consecutive conflicts. Responses are registered back to the
// owning requester.
// Optional build macro: ARB_TIMEOUT_EN (BUSY abort after TIMEOUT cycles).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_IF_WAIT = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] MAXW = 4'(MAX_IF_WAIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       grant_i, grant_d, done, abort;
  logic       tmo;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // BUSY cycle counter, restarted on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tcnt <= '0;
    else if (grant_i || grant_d) tcnt <= '0;
    else if (state != IDLE)      tcnt <= tcnt + 1'b1;
  end

  assign tmo = (state != IDLE) && (tcnt == TW'(TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT == 0);
  assign tmo        = 1'b0;
`endif

  // The port is requested for the whole time a transaction is owned
  assign mem_req = (state != IDLE);

  // State and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Grant decision in IDLE, completion/abort in BUSY
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || wait_cnt != MAXW)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
          if (if_req) wait_cnt_nxt = wait_cnt + 4'd1;
        end else if (if_req) begin
          grant_i      = 1'b1;
          state_nxt    = BUSY_I;
          wait_cnt_nxt = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture winner onto the memory port; register responses back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= abort;
      if (grant_i) begin
        mem_we    <= 1'b0;
        mem_size  <= 2'd2;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
      if (grant_d) begin
        mem_we    <= d_we;
        mem_size  <= d_size;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
      if (done || abort) begin
        if (state == BUSY_I) begin
          if_ready <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end else begin
          d_ready <= 1'b1;
          d_rdata <= done ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder with
// programmable wait states, expected-transaction and expected-response
// scoreboards. Timeout scenario is built only with ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_IF_WAIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          cyc;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    bit          err;
    int          cyc;
  } rsp_t;

  txn_t tq[$];
  rsp_t iq[$];
  rsp_t dq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int txn_seen = 0;
  int wait_states = 0;
  bit force_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) + 32'h1);
  endfunction

  function automatic void push_txn(input logic [31:0] a, input logic we,
                                   input logic [1:0] sz, input logic [31:0] wd, input int c);
    txn_t t;
    t.addr = a; t.we = we; t.size = sz; t.wdata = wd; t.cyc = c;
    tq.push_back(t);
  endfunction

  function automatic rsp_t mk_rsp(input logic [31:0] d, input bit chk, input bit e, input int c);
    rsp_t r;
    r.data = d; r.chk = chk; r.err = e; r.cyc = c;
    return r;
  endfunction

  // Memory responder: acks after wait_states extra cycles, checks each
  // transaction against the expected queue and its stability while pending
  bit          in_txn = 1'b0;
  int          wcnt = 0;
  int          reqcyc = 0;
  bit          stable = 1'b1;
  logic [66:0] cur;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!in_txn) begin
        txn_t t;
        in_txn = 1'b1;
        wcnt   = 0;
        reqcyc = 0;
        stable = 1'b1;
        cur    = {mem_we, mem_size, mem_addr, mem_wdata};
        txn_seen++;
        if (tq.size() == 0) begin
          check("txn_unexpected", 1, 0);
        end else begin
          t = tq.pop_front();
          check("mem_addr", mem_addr, t.addr);
          check("mem_we", mem_we, t.we);
          check("mem_size", mem_size, t.size);
          if (t.we) check("mem_wdata", mem_wdata, t.wdata);
          if (t.cyc >= 0) check("grant_cycle", cyc, t.cyc);
        end
      end else if ({mem_we, mem_size, mem_addr, mem_wdata} !== cur) begin
        stable = 1'b0;
      end
      reqcyc++;
      if (wcnt == wait_states) begin
        mem_ack   = 1'b1;
        mem_rdata = mdata(mem_addr);
        check("mem_stable", stable, 1);
        check("req_cycles", reqcyc, wait_states + 1);
        in_txn = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      in_txn    = 1'b0;
      mem_ack   = force_ack;
      mem_rdata = force_ack ? 32'hBAD0_BAD0 : 32'h0;
    end
  end

  // Response monitor: every ready pulse must match the head of its queue
  always @(negedge clk) begin
    rsp_t r;
    if (err && !if_ready && !d_ready) check("err_without_ready", err, 0);
    if (if_ready) begin
      if (iq.size() == 0) check("if_ready_unexpected", 1, 0);
      else begin
        r = iq.pop_front();
        if (r.chk) check("if_rdata", if_rdata, r.data);
        check("if_err", err, r.err);
        if (r.cyc >= 0) check("if_latency", cyc, r.cyc);
      end
    end
    if (d_ready) begin
      if (dq.size() == 0) check("d_ready_unexpected", 1, 0);
      else begin
        r = dq.pop_front();
        if (r.chk) check("d_rdata", d_rdata, r.data);
        check("d_err", err, r.err);
        if (r.cyc >= 0) check("d_latency", cyc, r.cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_txn(input int n);
    int k;
    k = 0;
    while (txn_seen < n && k < 500) begin
      tick();
      k++;
    end
    if (txn_seen < n) check("txn_wait_timeout", txn_seen, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((tq.size() != 0 || iq.size() != 0 || dq.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check("drain_pending", tq.size() + iq.size() + dq.size(), 0);
    repeat (3) tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    int base;
    base = txn_seen;
    push_txn(a, 1'b0, 2'd2, '0, -1);
    iq.push_back(mk_rsp(mdata(a), 1'b1, 1'b0, -1));
    if_addr = a;
    if_req  = 1'b1;
    wait_txn(base + 1);
    if_req = 1'b0;
    drain();
  endtask

  initial begin
    int base;
    int c;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    check("reset_mem", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, 0);
    check("reset_rsp", {if_ready, if_rdata, d_ready, d_rdata, err}, 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a stalled data load
    wait_states = 100;
    base = txn_seen;
    push_txn(32'h80, 1'b0, 2'd2, '0, -1);
    d_addr = 32'h80; d_we = 1'b0; d_size = 2'd2; d_req = 1'b1;
    wait_txn(base + 1);
    d_req = 1'b0;
    tick(); tick();
    check("busy_before_rst", mem_req, 1);
    rst = 1'b1;
    #1;
    check("midrst_mem", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, 0);
    check("midrst_rsp", {if_ready, if_rdata, d_ready, d_rdata, err}, 0);
    tick(); tick();
    rst = 1'b0;
    wait_states = 0;
    tick();
    fetch(32'h40);

    // Single zero-wait fetch with exact latency
    c = cyc;
    base = txn_seen;
    push_txn(32'h10, 1'b0, 2'd2, '0, c + 1);
    iq.push_back(mk_rsp(32'h0050_0093, 1'b1, 1'b0, c + 2));
    if_addr = 32'h10; if_req = 1'b1;
    wait_txn(base + 1);
    if_req = 1'b0;
    drain();

    // Simultaneous requests: store goes first, fetch follows
    base = txn_seen;
    push_txn(32'h100, 1'b1, 2'd2, 32'hDEAD_BEEF, -1);
    push_txn(32'h200, 1'b0, 2'd2, '0, -1);
    dq.push_back(mk_rsp('0, 1'b0, 1'b0, -1));
    iq.push_back(mk_rsp(mdata(32'h200), 1'b1, 1'b0, -1));
    d_addr = 32'h100; d_we = 1'b1; d_size = 2'd2; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    wait_txn(base + 1);
    d_req = 1'b0;
    wait_txn(base + 2);
    if_req = 1'b0;
    drain();

    // Continuous contention: D,D,D,D,I repeated
    base = txn_seen;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        push_txn(32'h300, 1'b0, 2'd2, '0, -1);
        iq.push_back(mk_rsp(mdata(32'h300), 1'b1, 1'b0, -1));
      end else begin
        push_txn(32'h400, 1'b0, 2'd1, '0, -1);
        dq.push_back(mk_rsp(mdata(32'h400), 1'b1, 1'b0, -1));
      end
    end
    d_addr = 32'h400; d_we = 1'b0; d_size = 2'd1; d_wdata = '0; d_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    wait_txn(base + 10);
    d_req = 1'b0; if_req = 1'b0;
    drain();

    // Byte load with three memory wait states
    wait_states = 3;
    c = cyc;
    base = txn_seen;
    push_txn(32'h123, 1'b0, 2'd0, '0, c + 1);
    dq.push_back(mk_rsp(mdata(32'h123), 1'b1, 1'b0, c + 5));
    d_addr = 32'h123; d_we = 1'b0; d_size = 2'd0; d_req = 1'b1;
    wait_txn(base + 1);
    d_req = 1'b0;
    drain();
    wait_states = 0;

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort with err, late ack ignored
    wait_states = 100000;
    base = txn_seen;
    push_txn(32'h500, 1'b0, 2'd2, '0, -1);
    dq.push_back(mk_rsp('0, 1'b1, 1'b1, -1));
    d_addr = 32'h500; d_we = 1'b0; d_size = 2'd2; d_req = 1'b1;
    wait_txn(base + 1);
    d_req = 1'b0;
    drain();
    wait_states = 0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick(); tick();
    check("late_ack_idle", {mem_req, d_ready, if_ready, err}, 0);
    fetch(32'h600);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the pipelined CPU's instruction-fetch (IF) and data-access (MEM) requesters. It serialises transactions through a small FSM and gives data requests priority, with a starvation guard so fetches still make progress. It also registers the response back to whichever requester owns the port. It sits between PipelinedCPU's IF/MEM stages and the shared memory model.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of read and write data
MAX_IF_WAIT, 4, number of consecutive IF losses after which IF wins the next conflict (range 1..15)
TIMEOUT, 64, cycles in BUSY without mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; asynchronous, active-high
if_req  in  1  fetch request; level, sampled in IDLE
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  registered fetch data
d_req  in  1  data request; level, sampled in IDLE
d_we  in  1  1 = store, 0 = load
d_size  in  2  0 = byte, 1 = half, 2 = word
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle pulse; d_rdata valid (loads)
d_rdata  out  DATA_W  registered load data
mem_req  out  1  memory request; held high until mem_ack
mem_we  out  1  write enable to memory
mem_size  out  2  access size to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  memory completion; may be high in the first mem_req cycle
err  out  1  one-cycle timeout pulse; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset values: FSM = IDLE, starvation counter = 0, and all outputs are 0. This includes both ready and rdata outputs, every mem_* output and err.
- Reset mid-transaction: the transaction is abandoned, no ready pulse is issued, and the outputs return to 0 immediately.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, no request: the FSM stays in IDLE.
- IDLE, only if_req: go to BUSY_I and clear the starvation counter.
- IDLE, only d_req: go to BUSY_D.
- IDLE, both requests, counter < MAX_IF_WAIT: BUSY_D wins and the counter increments.
- IDLE, both requests, counter = MAX_IF_WAIT: BUSY_I wins and the counter clears.
- Grant edge: the winner's address, size, we and wdata are captured into the mem_* registers. An IF grant forces mem_we = 0 and mem_size = 2.
- BUSY_x: mem_req = 1 and all mem_* outputs are held stable.
- BUSY_x with mem_ack = 1: mem_rdata is captured into x_rdata, x_ready pulses on the next cycle, mem_req drops, and the FSM returns to IDLE.
- Timing: the response arrives on the same edge the FSM re-enters IDLE. Latency from a request sampled at edge N with zero-wait memory is x_ready high in cycle N+2. Each memory wait state adds 1 cycle.
- Back-to-back: a requester whose req is still high during its ready cycle is treated as a new request, using the address present in that cycle.
- Store completion: d_ready pulses on a store; d_rdata holds mem_rdata as sampled at ack (value undefined and not checked).
- Data hold: if_rdata and d_rdata hold their value until the next respective completion.
- Request stability: requesters keep their inputs stable only until the grant edge; the arbiter never re-samples during BUSY.
- Starvation counter: saturates at MAX_IF_WAIT and changes only on IDLE grant decisions.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in BUSY_x, clearing on each entry to BUSY. If it reaches TIMEOUT with no mem_ack:
  - mem_req drops and the FSM returns to IDLE;
  - err pulses 1 cycle together with x_ready, and x_rdata is set to 0;
  - a late mem_ack while in IDLE is ignored.
- Not defined: no counter; BUSY waits indefinitely and err is tied to 0.

Test Plan:
1. Reset check: assert rst mid-BUSY_D (mem_ack held 0) -> all outputs go to 0 at once, no d_ready; after release, if_req is granted normally.
2. Single fetch: if_req, if_addr = 0x00000010, memory acks with 0 wait, mem_rdata = 0x00500093 -> mem_addr = 0x10, mem_we = 0, mem_size = 2 in cycle N+1; if_ready = 1 and if_rdata = 0x00500093 in cycle N+2.
3. Data priority: if_req and d_req both high, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_size = 2 -> memory sees write 0x100/0xDEADBEEF first; IF is served after d_ready.
4. Starvation: if_req and d_req held high continuously, MAX_IF_WAIT = 4 -> grant order D, D, D, D, I, D, D, D, D, I.
5. Wait states: memory delays mem_ack by 3 cycles on a load, d_size = 0 -> mem_req stays high for 4 cycles with stable mem_* outputs; d_ready arrives in cycle N+5.
6. Timeout (ARB_TIMEOUT_EN, TIMEOUT = 8): mem_ack never asserted -> err and d_ready pulse together, d_rdata = 0, FSM returns to IDLE; a later mem_ack pulse has no effect.
